// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone arbiter.
// Watchdog is built only when WB_ARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  localparam int DEF_NUM_MASTERS    = 2;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin picker: first requester
// searching upward from ptr+1, modulo N.
module wb_arb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_MASTERS,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone B4 classic round-robin arbiter.
// Define WB_ARB_TIMEOUT_EN to build the stalled-strobe watchdog.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  output logic [DATA_W-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_adr_o,
  output logic [DATA_W-1:0]               s_dat_o,
  output logic [DATA_W/8-1:0]             s_sel_o,
  input  logic [DATA_W-1:0]               s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  output logic [NUM_MASTERS-1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IW    = idx_w(NUM_MASTERS);

  arb_state_e             state;
  logic [IW-1:0]          rr_ptr;
  logic [NUM_MASTERS-1:0] pick;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic                   busy;
  logic                   to_fire;

  wb_arb_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req   (m_cyc_i),
    .ptr   (rr_ptr),
    .grant (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (pick[i]) pick_idx = IW'(i);
  end

  assign busy = (state == ARB_BUSY);

  // rr_ptr doubles as the granted index while BUSY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ARB_IDLE;
      grant_o <= '0;
      rr_ptr  <= IW'(NUM_MASTERS - 1);
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state   <= ARB_BUSY;
            grant_o <= pick;
            rr_ptr  <= pick_idx;
          end
        end
        ARB_BUSY: begin
          if (!m_cyc_i[rr_ptr]) begin
            state   <= ARB_IDLE;
            grant_o <= '0;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (busy) begin
      s_cyc_o = m_cyc_i[rr_ptr];
      s_stb_o = m_stb_i[rr_ptr];
      s_we_o  = m_we_i[rr_ptr];
      s_adr_o = m_adr_i[rr_ptr*ADDR_W +: ADDR_W];
      s_dat_o = m_dat_i[rr_ptr*DATA_W +: DATA_W];
      s_sel_o = m_sel_i[rr_ptr*SEL_W +: SEL_W];
    end
  end

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      m_ack_o[rr_ptr] = s_ack_i;
      m_err_o[rr_ptr] = s_err_i | to_fire;
    end
  end

  assign m_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;

  logic [WD_W-1:0] wd;
  logic            stall;

  // A slave termination in the firing cycle suppresses the timeout
  assign stall   = busy && s_stb_o && !s_ack_i && !s_err_i;
  assign to_fire = stall && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wd <= '0;
    else if (!stall || to_fire)
      wd <= '0;
    else
      wd <= wd + WD_W'(1);
  end
`else
  logic unused_timeout;

  assign to_fire        = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with two masters.
// The watchdog scenario runs when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    m_cyc = '0;
  logic [N-1:0]    m_stb = '0;
  logic [N-1:0]    m_we = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [N*4-1:0]  m_sel = '0;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [3:0]      s_sel_o;
  logic [DW-1:0]   s_dat = '0;
  logic            s_ack = 1'b0;
  logic            s_err = 1'b0;
  logic [N-1:0]    grant_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .grant_o (grant_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    total++;
    if (grant_o !== 2'b00) $display("FAIL reset_grant got %b exp 00", grant_o);
    else passed++;
    total++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("FAIL reset_scyc got %b%b exp 00", s_cyc_o, s_stb_o);
    else passed++;
    total++;
    if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) $display("FAIL reset_ack got %b/%b exp 00/00", m_ack_o, m_err_o);
    else passed++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_we[0]  = 1'b1;
    m_adr[31:0] = 32'h0000_1000;
    m_dat[31:0] = 32'hDEAD_BEEF;
    m_sel[3:0]  = 4'hF;
    #1;
    total++;
    if (s_cyc_o !== 1'b0) $display("FAIL single_latency got %b exp 0", s_cyc_o);
    else passed++;
    tick();
    total++;
    if (s_cyc_o !== 1'b1 || grant_o !== 2'b01) $display("FAIL single_grant got cyc %b grant %b exp 1 01", s_cyc_o, grant_o);
    else passed++;
    total++;
    if (s_adr_o !== 32'h1000 || s_dat_o !== 32'hDEAD_BEEF) $display("FAIL single_route got %h %h exp 00001000 deadbeef", s_adr_o, s_dat_o);
    else passed++;
    total++;
    if (s_sel_o !== 4'hF || s_we_o !== 1'b1 || s_stb_o !== 1'b1) $display("FAIL single_ctrl got sel %h we %b stb %b exp f 1 1", s_sel_o, s_we_o, s_stb_o);
    else passed++;
    s_ack = 1'b1;
    #1;
    total++;
    if (m_ack_o !== 2'b01) $display("FAIL single_ack got %b exp 01", m_ack_o);
    else passed++;
    idle_all();
  endtask

  task automatic test_alternate();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    tick();
    total++;
    if (grant_o !== 2'b01) $display("FAIL alt_first got %b exp 01", grant_o);
    else passed++;
    m_cyc[0] = 1'b0;
    tick();
    total++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) $display("FAIL alt_dead1 got grant %b cyc %b exp 00 0", grant_o, s_cyc_o);
    else passed++;
    m_cyc[0] = 1'b1;
    tick();
    total++;
    if (grant_o !== 2'b10) $display("FAIL alt_second got %b exp 10", grant_o);
    else passed++;
    m_cyc[1] = 1'b0;
    tick();
    total++;
    if (grant_o !== 2'b00) $display("FAIL alt_dead2 got %b exp 00", grant_o);
    else passed++;
    m_cyc[1] = 1'b1;
    tick();
    total++;
    if (grant_o !== 2'b01) $display("FAIL alt_third got %b exp 01", grant_o);
    else passed++;
    idle_all();
  endtask

  task automatic test_hold();
    logic [31:0] vals [3];
    vals[0] = 32'h11;
    vals[1] = 32'h22;
    vals[2] = 32'h33;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    tick();
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_dat = vals[i];
      s_ack = 1'b1;
      #1;
      total++;
      if (grant_o !== 2'b10 || m_ack_o !== 2'b10) $display("FAIL hold_grant%0d got grant %b ack %b exp 10 10", i, grant_o, m_ack_o);
      else passed++;
      total++;
      if (m_dat_o !== vals[i]) $display("FAIL hold_data%0d got %h exp %h", i, m_dat_o, vals[i]);
      else passed++;
      tick();
    end
    s_ack = 1'b0;
    m_cyc[1] = 1'b0;
    tick();
    tick();
    total++;
    if (grant_o !== 2'b01) $display("FAIL hold_after got %b exp 01", grant_o);
    else passed++;
    idle_all();
  endtask

  task automatic test_stray_ack();
    s_ack = 1'b1;
    s_err = 1'b1;
    #1;
    total++;
    if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) $display("FAIL stray_fwd got %b/%b exp 00/00", m_ack_o, m_err_o);
    else passed++;
    tick();
    total++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) $display("FAIL stray_state got grant %b cyc %b exp 00 0", grant_o, s_cyc_o);
    else passed++;
    s_ack = 1'b0;
    s_err = 1'b0;
    tick();
  endtask

  task automatic test_err_and_drop();
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    tick();
    s_err = 1'b1;
    #1;
    total++;
    if (m_err_o !== 2'b01 || m_ack_o !== 2'b00) $display("FAIL err_fwd got err %b ack %b exp 01 00", m_err_o, m_ack_o);
    else passed++;
    tick();
    s_err = 1'b0;
    s_ack = 1'b1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    #1;
    total++;
    if (m_ack_o !== 2'b01) $display("FAIL drop_ack got %b exp 01", m_ack_o);
    else passed++;
    tick();
    total++;
    if (grant_o !== 2'b00 || m_ack_o !== 2'b00) $display("FAIL drop_release got grant %b ack %b exp 00 00", grant_o, m_ack_o);
    else passed++;
    idle_all();
  endtask

  task automatic test_reset_mid();
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    tick();
    total++;
    if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) $display("FAIL rstmid_pre got grant %b cyc %b exp 10 1", grant_o, s_cyc_o);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) $display("FAIL rstmid_async got grant %b cyc %b stb %b exp 00 0 0", grant_o, s_cyc_o, s_stb_o);
    else passed++;
    reset_n = 1'b1;
    m_cyc = 2'b11;
    m_stb = 2'b11;
    tick();
    total++;
    if (grant_o !== 2'b01) $display("FAIL rstmid_first got %b exp 01", grant_o);
    else passed++;
    idle_all();
  endtask

  task automatic test_timeout();
    logic [1:0] exp_err;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int n = 1; n <= 9; n++) begin
      exp_err = (n == 8) ? 2'b01 : 2'b00;
      #1;
      total++;
      if (m_err_o !== exp_err) $display("FAIL timeout_c%0d got %b exp %b", n, m_err_o, exp_err);
      else passed++;
      tick();
    end
    for (int n = 2; n <= 7; n++) tick();
    s_ack = 1'b1;
    #1;
    total++;
    if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) $display("FAIL timeout_ackwin got ack %b err %b exp 01 00", m_ack_o, m_err_o);
    else passed++;
    tick();
    s_ack = 1'b0;
    #1;
    total++;
    if (m_err_o !== 2'b00) $display("FAIL timeout_after got %b exp 00", m_err_o);
    else passed++;
`else
    exp_err = 2'b00;
    for (int n = 1; n <= 10; n++) begin
      #1;
      if (n == 8 || n == 10) begin
        total++;
        if (m_err_o !== exp_err) $display("FAIL nowd_c%0d got %b exp %b", n, m_err_o, exp_err);
        else passed++;
      end
      tick();
    end
`endif
    idle_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_stray_ack();
    test_err_and_drop();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
